// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with registered, write-first
// read ports and a per-register pending-write scoreboard.
// Optional build macro REG_FILE_ZERO_REG_EN: register 0 hardwired to zero
// (writes and reservations of address 0 are ignored).
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(2**ADDR_W)-1:0]   pend_vec
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_pend;
  logic [DEPTH-1:0]         w_pend_next;
  logic                     w_we_eff;
  logic                     w_rsv_eff;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_busy;

  // Qualify write and reserve; with the zero register, address 0 is inert,
  // so its storage and pending bit never leave their reset value of 0.
  always_comb begin
`ifdef REG_FILE_ZERO_REG_EN
    w_we_eff  = we && (wr_addr != '0);
    w_rsv_eff = rsv_en && (rsv_addr != '0);
`else
    w_we_eff  = we;
    w_rsv_eff = rsv_en;
`endif
  end

  // Scoreboard next state: a reserve beats a same-cycle write (new producer wins).
  always_comb begin
    w_pend_next = r_pend;
    for (int unsigned n = 0; n < DEPTH; n++) begin
      if (w_rsv_eff && (rsv_addr == ADDR_W'(n)))
        w_pend_next[n] = 1'b1;
      else if (w_we_eff && (wr_addr == ADDR_W'(n)))
        w_pend_next[n] = 1'b0;
    end
  end

  // Write-first read: bypass wr_data on an address match; busy follows pend_next.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (w_we_eff && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]))
        w_rd_data[i*DATA_W +: DATA_W] = wr_data;
      else
        w_rd_data[i*DATA_W +: DATA_W] = r_mem[rd_addr[i*ADDR_W +: ADDR_W]];
      w_rd_busy[i] = w_pend_next[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  // Register storage; clr clears every entry and dominates we.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned n = 0; n < DEPTH; n++)
        r_mem[n] <= '0;
    end else if (w_we_eff) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Pending bits and registered read outputs; clr discards all reservations.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pend    <= '0;
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      r_pend    <= w_pend_next;
      r_rd_data <= w_rd_data;
      r_rd_busy <= w_rd_busy;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_busy  = r_rd_busy;
  assign pend_vec = r_pend;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param (DATA_W=32, ADDR_W=4, NUM_RD=2).
// Stimulus pushes hand-computed expectations; a monitor pops one entry per
// clock edge and compares. Build with +define+REG_FILE_ZERO_REG_EN to check
// the zero-register variant.
module tb_reg_file_param;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            we = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            rsv_en = 1'b0;
  logic [AW-1:0]   rsv_addr = '0;
  logic [15:0]     pend_vec;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    busy;
    logic [15:0]   pend;
    string         name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .clr(clr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  // Drive one cycle of inputs on the falling edge and queue the response
  // expected right after the following rising edge.
  task automatic step(input bit c, input bit w, input logic [3:0] wa,
                      input logic [31:0] wd, input bit r, input logic [3:0] ra,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input logic [15:0] ep,
                      input string nm);
    exp_t e;
    @(negedge clk);
    clr = c; we = w; wr_addr = wa; wr_data = wd;
    rsv_en = r; rsv_addr = ra; rd_addr = {a1, a0};
    e.d0 = e0; e.d1 = e1; e.busy = eb; e.pend = ep; e.name = nm;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, what, act, exp);
    end
  endtask

  // Monitor: one registered response per rising edge while entries are queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "rd_data0", rd_data[DW-1:0],    e.d0);
        chk(e.name, "rd_data1", rd_data[2*DW-1:DW], e.d1);
        chk(e.name, "rd_busy",  {30'd0, rd_busy},   {30'd0, e.busy});
        chk(e.name, "pend_vec", {16'd0, pend_vec},  {16'd0, e.pend});
      end
    end
  end

  initial begin
    // Reset dominates a same-cycle write and reserve.
    step(1, 1, 4'd3, 32'hDEADBEEF, 1, 4'd3, 4'd3, 4'd3, 0, 0, 2'b00, 16'h0, "reset");
    for (int a = 0; a < 16; a++)
      step(0, 0, 0, 0, 0, 0, 4'(a), 4'(15 - a), 0, 0, 2'b00, 16'h0, "readback");
    // Write then read with one-cycle latency.
    step(0, 1, 4'd5, 32'h12345678, 0, 0, 4'd0, 4'd0, 0, 0, 2'b00, 16'h0, "wr5");
    step(0, 0, 0, 0, 0, 0, 4'd5, 4'd6, 32'h12345678, 0, 2'b00, 16'h0, "rd5_6");
    // Write-first bypass on both ports.
    step(0, 1, 4'd7, 32'h1, 0, 0, 4'd0, 4'd0, 0, 0, 2'b00, 16'h0, "wr7");
    step(0, 1, 4'd7, 32'hA5A5A5A5, 0, 0, 4'd7, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 16'h0, "bypass7");
    step(0, 0, 0, 0, 0, 0, 4'd7, 4'd5, 32'hA5A5A5A5, 32'h12345678, 2'b00, 16'h0, "rd7_5");
    // Scoreboard.
    step(0, 0, 0, 0, 1, 4'd9, 4'd9, 4'd9, 0, 0, 2'b11, 16'h0200, "rsv9");
    step(0, 1, 4'd9, 32'h55, 0, 0, 4'd9, 4'd7, 32'h55, 32'hA5A5A5A5, 2'b00, 16'h0, "wr9_clear");
    step(0, 1, 4'd9, 32'h77, 1, 4'd9, 4'd9, 4'd9, 32'h77, 32'h77, 2'b11, 16'h0200, "rsv_wr9");
    step(0, 0, 0, 0, 1, 4'd2, 4'd2, 4'd4, 0, 0, 2'b01, 16'h0204, "rsv2");
    step(0, 0, 0, 0, 1, 4'd4, 4'd2, 4'd4, 0, 0, 2'b11, 16'h0214, "rsv4");
    step(0, 0, 0, 0, 1, 4'd11, 4'd11, 4'd9, 0, 32'h77, 2'b11, 16'h0A14, "rsv11");
    // Reset mid-operation.
    step(1, 0, 0, 0, 0, 0, 4'd11, 4'd9, 0, 0, 2'b00, 16'h0, "clr_mid");
    for (int a = 0; a < 16; a++)
      step(0, 0, 0, 0, 0, 0, 4'(a), 4'(a ^ 5), 0, 0, 2'b00, 16'h0, "post_clr");
    // Register 0 behaviour depends on the build.
    if (ZR) begin
      step(0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 4'd0, 4'd0, 0, 0, 2'b00, 16'h0, "zero_wr");
      step(0, 0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0, 2'b00, 16'h0, "zero_rd");
      step(0, 1, 4'd5, 32'hABCD, 1, 4'd1, 4'd1, 4'd5, 0, 32'hABCD, 2'b01, 16'h0002, "wr5_rsv1");
    end else begin
      step(0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 16'h0001, "zero_wr");
      step(0, 0, 0, 0, 0, 0, 4'd0, 4'd5, 32'hFFFFFFFF, 0, 2'b01, 16'h0001, "zero_rd");
      step(0, 1, 4'd5, 32'hABCD, 1, 4'd1, 4'd1, 4'd5, 0, 32'hABCD, 2'b01, 16'h0003, "wr5_rsv1");
    end
    @(negedge clk);
    clr = 0; we = 0; rsv_en = 0;
    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
